// File: rtl/lfsr_dec_pkg.sv
// Shared types and constants for the LFSR stream decryptor.
// Holds the run-state encoding, the default tap table and the LFSR step.
package lfsr_dec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRAIN,
        DECIDE,
        DECODE,
        FIN
    } dec_state_t;

    localparam int DEF_W     = 6;
    localparam int DEF_NTAPS = 6;

    // Lane 0 is the leftmost (most significant) entry of the packed table.
    localparam logic [DEF_NTAPS*DEF_W-1:0] DEF_TAPS =
        {6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

    localparam logic [7:0] DEF_PAD = 8'h5F;

    // One Fibonacci step of a w-bit register, carried in an 8-bit container.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s,
                                             input logic [7:0] taps,
                                             input int         w);
        logic [7:0] mask;
        mask = 8'((9'd1 << w) - 9'd1);
        return ((s << 1) | {7'd0, ^(s & taps)}) & mask;
    endfunction

endpackage

// File: rtl/lfsr_decrypt_engine_lfsr_nb.sv
// W-bit LFSR lane: load takes priority over stepping.
// Lane contents are pure data and are always reloaded before use, so no reset.
module lfsr_nb
    import lfsr_dec_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] taps,
    input  logic [W-1:0] seed,
    output logic [W-1:0] state
);

    always_ff @(posedge clk) begin
        if (load) begin
            state <= seed;
        end else if (en) begin
            state <= W'(lfsr_step(8'(state), 8'(taps), W));
        end
    end

endmodule

// File: rtl/lfsr_decrypt_engine.sv
// LFSR stream decryptor: trains NTAPS candidate lanes on a PAD preamble,
// picks the matching lane, then writes the decrypted message back to memory.
module lfsr_decrypt_engine
    import lfsr_dec_pkg::*;
#(
    parameter int               W         = DEF_W,
    parameter int               NTAPS     = DEF_NTAPS,
    parameter logic [NTAPS*W-1:0] TAPS    = DEF_TAPS,
    parameter int               PRE_LEN   = 7,
    parameter int               MSG_LEN   = 64,
    parameter logic [7:0]       RD_BASE   = 8'd64,
    parameter logic [7:0]       WR_BASE   = 8'd0,
    parameter logic [7:0]       PAD       = DEF_PAD,
    parameter bit               STRIP_PAD = 1'b0
) (
    input  logic       clk,
    input  logic       init,
    input  logic       start,
    output logic [7:0] raddr,
    input  logic [7:0] rdata,
    output logic       wr_en,
    output logic [7:0] waddr,
    output logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       amb,
    output logic [$clog2(NTAPS > 1 ? NTAPS : 2)-1:0] tap_sel,
    output logic [8:0] wr_count
);

    localparam int SEL_W = $clog2(NTAPS > 1 ? NTAPS : 2);
    localparam int CNT_W = 16;

    dec_state_t state, next_state;

    logic [CNT_W-1:0] k;
    logic [CNT_W-1:0] j;
    logic [W-1:0]     seed_reg;
    logic [NTAPS-1:0] cand;
    logic             lead;

    logic [W-1:0]     lane_state [NTAPS];
    logic [W-1:0]     lane_next  [NTAPS];
    logic [NTAPS-1:0] lane_en;
    logic             lane_load;
    logic [W-1:0]     load_val;
    logic [W-1:0]     pre_sym;
    logic [7:0]       dec_byte;

    function automatic logic [SEL_W-1:0] lowest_set(input logic [NTAPS-1:0] v);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = NTAPS - 1; i >= 0; i--) begin
            if (v[i]) idx = SEL_W'(i);
        end
        return idx;
    endfunction

    function automatic logic multi_hit(input logic [NTAPS-1:0] v);
        return $countones(v) > 1;
    endfunction

    for (genvar g = 0; g < NTAPS; g++) begin : g_lane
        localparam logic [W-1:0] LANE_TAPS = TAPS[(NTAPS-1-g)*W +: W];

        lfsr_nb #(.W(W)) u_lane (
            .clk   (clk),
            .en    (lane_en[g]),
            .load  (lane_load),
            .taps  (LANE_TAPS),
            .seed  (load_val),
            .state (lane_state[g])
        );

        assign lane_next[g] = W'(lfsr_step(8'(lane_state[g]), 8'(LANE_TAPS), W));
    end

    always_ff @(posedge clk) begin
        if (init) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = TRAIN;
            TRAIN:   if (k == CNT_W'(PRE_LEN - 1)) next_state = DECIDE;
            DECIDE:  next_state = (cand == '0) ? FIN : DECODE;
            DECODE:  if (j == CNT_W'(MSG_LEN - 1)) next_state = FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Write port is combinational so a write lands on the edge closing its DECODE cycle.
    always_comb begin
        lane_load = 1'b0;
        lane_en   = '0;
        load_val  = seed_reg;
        wr_en     = 1'b0;
        wdata     = 8'd0;
        pre_sym   = rdata[W-1:0] ^ PAD[W-1:0];
        dec_byte  = rdata ^ 8'(lane_state[tap_sel]);
        case (state)
            TRAIN: begin
                if (k == '0) begin
                    lane_load = 1'b1;
                    load_val  = pre_sym;
                end else begin
                    lane_en = '1;
                end
            end
            DECIDE: lane_load = 1'b1;
            DECODE: begin
                lane_en[tap_sel] = 1'b1;
                wdata            = dec_byte;
                wr_en            = !(STRIP_PAD && lead && (dec_byte == PAD));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            raddr    <= 8'd0;
            waddr    <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            amb      <= 1'b0;
            tap_sel  <= '0;
            wr_count <= 9'd0;
            k        <= '0;
            j        <= '0;
            lead     <= 1'b0;
        end else begin
            busy <= (next_state != IDLE);
            done <= (next_state == FIN);
            case (state)
                IDLE: begin
                    if (start) begin
                        raddr    <= RD_BASE;
                        k        <= '0;
                        err      <= 1'b0;
                        amb      <= 1'b0;
                        tap_sel  <= '0;
                        wr_count <= 9'd0;
                    end
                end
                TRAIN: begin
                    raddr <= raddr + 8'd1;
                    k     <= k + CNT_W'(1);
                end
                DECIDE: begin
                    if (cand == '0) begin
                        err <= 1'b1;
                    end else begin
                        tap_sel <= lowest_set(cand);
                        amb     <= multi_hit(cand);
                    end
                    raddr <= RD_BASE;
                    waddr <= WR_BASE;
                    j     <= '0;
                    lead  <= 1'b1;
                end
                DECODE: begin
                    raddr <= raddr + 8'd1;
                    j     <= j + CNT_W'(1);
                    if (wr_en) begin
                        waddr    <= waddr + 8'd1;
                        wr_count <= wr_count + 9'd1;
                    end
                    if (dec_byte != PAD) lead <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Seed and candidate mask are rebuilt at the start of every training pass.
    always_ff @(posedge clk) begin
        if (state == TRAIN) begin
            if (k == '0) begin
                seed_reg <= pre_sym;
                cand     <= '1;
            end else begin
                for (int i = 0; i < NTAPS; i++) begin
                    cand[i] <= cand[i] & (lane_next[i] == pre_sym);
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// Randomised bench for lfsr_decrypt_engine: four parameterisations, each run
// against a reference model that recomputes keystreams and lane matches directly.
module tb_lfsr_decrypt_engine;

    localparam logic [7:0] PAD = 8'h5F;
    localparam int ND = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       init;
    logic       start    [ND];
    logic [7:0] raddr    [ND];
    logic [7:0] rdata    [ND];
    logic [7:0] waddr    [ND];
    logic [7:0] wdata    [ND];
    logic       wr_en    [ND];
    logic       busy     [ND];
    logic       done     [ND];
    logic       err      [ND];
    logic       amb      [ND];
    logic [2:0] tap_sel  [ND];
    logic [8:0] wr_count [ND];

    logic [7:0] mem [ND][256];
    logic [7:0] pt  [ND][256];
    logic [7:0] tap_of [6];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < ND; g++) begin : g_rd
        assign rdata[g] = mem[g][raddr[g]];
    end

    lfsr_decrypt_engine u_def (
        .clk(clk), .init(init), .start(start[0]), .raddr(raddr[0]), .rdata(rdata[0]),
        .wr_en(wr_en[0]), .waddr(waddr[0]), .wdata(wdata[0]), .busy(busy[0]), .done(done[0]),
        .err(err[0]), .amb(amb[0]), .tap_sel(tap_sel[0]), .wr_count(wr_count[0])
    );

    lfsr_decrypt_engine #(.STRIP_PAD(1'b1)) u_strip (
        .clk(clk), .init(init), .start(start[1]), .raddr(raddr[1]), .rdata(rdata[1]),
        .wr_en(wr_en[1]), .waddr(waddr[1]), .wdata(wdata[1]), .busy(busy[1]), .done(done[1]),
        .err(err[1]), .amb(amb[1]), .tap_sel(tap_sel[1]), .wr_count(wr_count[1])
    );

    lfsr_decrypt_engine #(.RD_BASE(8'd200), .WR_BASE(8'd100)) u_base (
        .clk(clk), .init(init), .start(start[2]), .raddr(raddr[2]), .rdata(rdata[2]),
        .wr_en(wr_en[2]), .waddr(waddr[2]), .wdata(wdata[2]), .busy(busy[2]), .done(done[2]),
        .err(err[2]), .amb(amb[2]), .tap_sel(tap_sel[2]), .wr_count(wr_count[2])
    );

    lfsr_decrypt_engine #(.PRE_LEN(1)) u_pre1 (
        .clk(clk), .init(init), .start(start[3]), .raddr(raddr[3]), .rdata(rdata[3]),
        .wr_en(wr_en[3]), .waddr(waddr[3]), .wdata(wdata[3]), .busy(busy[3]), .done(done[3]),
        .err(err[3]), .amb(amb[3]), .tap_sel(tap_sel[3]), .wr_count(wr_count[3])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Keystream recurrence written from the definition: shift left, feed back tap parity.
    function automatic logic [7:0] ks_step(input logic [7:0] s, input logic [7:0] t);
        return ((s << 1) | 8'($countones(s & t) % 2)) & 8'h3F;
    endfunction

    task automatic build(input int d, input int lane, input int pre, input int mlen,
                         input int rb, input int npad);
        logic [7:0] s;
        for (int a = 0; a < 256; a++) mem[d][a] = 8'($urandom);
        s = 8'($urandom_range(1, 63));
        for (int jj = 0; jj < mlen; jj++) begin
            pt[d][jj] = (jj < npad || jj < pre) ? PAD : 8'($urandom_range(65, 90));
            mem[d][(rb + jj) % 256] = pt[d][jj] ^ s;
            s = ks_step(s, tap_of[lane]);
        end
    endtask

    task automatic run(input int d, input int pre, input int mlen, input int rb, input int wb,
                       input bit strip, input int lane_built, input int abort_at,
                       input int restart_at);
        logic [7:0] seed, s, b;
        logic [7:0] exp_a[$];
        logic [7:0] exp_d[$];
        int         exp_j[$];
        int ok, sel, nmatch, nw, done_cyc;
        bit lead, exp_err;

        seed   = (mem[d][rb] ^ PAD) & 8'h3F;
        nmatch = 0;
        sel    = -1;
        for (int l = 0; l < 6; l++) begin
            s  = seed;
            ok = 1;
            for (int kk = 1; kk < pre; kk++) begin
                s = ks_step(s, tap_of[l]);
                if (s != ((mem[d][(rb + kk) % 256] ^ PAD) & 8'h3F)) ok = 0;
            end
            if (ok != 0) begin
                nmatch++;
                if (sel < 0) sel = l;
            end
        end
        exp_err = (nmatch == 0);
        if (!exp_err) begin
            s    = seed;
            lead = 1'b1;
            for (int jj = 0; jj < mlen; jj++) begin
                b = mem[d][(rb + jj) % 256] ^ s;
                if (!(strip && lead && b == PAD)) begin
                    exp_a.push_back(8'((wb + exp_a.size()) % 256));
                    exp_d.push_back(b);
                    exp_j.push_back(jj);
                end
                if (b != PAD) lead = 1'b0;
                s = ks_step(s, tap_of[sel]);
            end
        end

        @(negedge clk);
        start[d] = 1'b1;
        nw       = 0;
        done_cyc = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start[d] = (c == restart_at);
            if (abort_at > 0 && c == abort_at) init = 1'b1;
            if (abort_at > 0 && c > abort_at) begin
                init = 1'b0;
                check("abort_wr_en", wr_en[d], 0);
                check("abort_busy", busy[d], 0);
                if (c == abort_at + 1) check("abort_wr_count", wr_count[d], 0);
                if (c == abort_at + 4) break;
                continue;
            end
            if (c <= pre)
                check("raddr_train", raddr[d], (rb + c - 1) % 256);
            else if (!exp_err && c >= pre + 2 && c <= pre + 1 + mlen)
                check("raddr_decode", raddr[d], (rb + c - pre - 2) % 256);
            if (wr_en[d]) begin
                if (nw < exp_a.size()) begin
                    check("waddr", waddr[d], exp_a[nw]);
                    check("wdata", wdata[d], exp_d[nw]);
                    check("wr_cycle", c, pre + 2 + exp_j[nw]);
                    if (sel == lane_built) check("plaintext", wdata[d], pt[d][exp_j[nw]]);
                end else begin
                    check("extra_write", nw + 1, exp_a.size());
                end
                nw++;
            end
            if (done[d]) begin
                done_cyc = c;
                break;
            end
        end

        if (abort_at < 0) begin
            check("done_cycle", done_cyc, exp_err ? pre + 2 : pre + 2 + mlen);
            check("writes", nw, exp_a.size());
            check("wr_count", wr_count[d], exp_a.size());
            check("err", err[d], exp_err);
            check("amb", amb[d], nmatch > 1);
            check("tap_sel", tap_sel[d], exp_err ? 0 : sel);
            check("busy_fin", busy[d], 1);
            @(negedge clk);
            check("done_pulse", done[d], 0);
            check("busy_idle", busy[d], 0);
            repeat (3) @(negedge clk);
            check("hold_wr_count", wr_count[d], exp_a.size());
            check("hold_tap_sel", tap_sel[d], exp_err ? 0 : sel);
            check("hold_err", err[d], exp_err);
            check("idle_wr_en", wr_en[d], 0);
        end
    endtask

    initial begin
        int lane;
        tap_of = '{8'h21, 8'h2D, 8'h30, 8'h33, 8'h36, 8'h39};
        init = 1'b1;
        for (int d = 0; d < ND; d++) begin
            start[d] = 1'b0;
            build(d, 0, 7, 64, 64, 7);
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check("rst_raddr", raddr[d], 0);
            check("rst_waddr", waddr[d], 0);
            check("rst_wdata", wdata[d], 0);
            check("rst_wr_en", wr_en[d], 0);
            check("rst_busy", busy[d], 0);
            check("rst_done", done[d], 0);
            check("rst_err", err[d], 0);
            check("rst_amb", amb[d], 0);
            check("rst_tap_sel", tap_sel[d], 0);
            check("rst_wr_count", wr_count[d], 0);
        end
        init = 1'b0;

        build(0, 3, 7, 64, 64, 7);
        run(0, 7, 64, 64, 0, 1'b0, 3, -1, -1);

        for (int r = 0; r < 3; r++) begin
            lane = $urandom_range(0, 5);
            build(0, lane, 7, 64, 64, 7);
            run(0, 7, 64, 64, 0, 1'b0, lane, -1, (r == 0) ? 20 : -1);
        end

        build(0, 3, 7, 64, 64, 7);
        mem[0][67] = mem[0][67] ^ 8'h01;
        run(0, 7, 64, 64, 0, 1'b0, 3, -1, -1);

        build(0, 3, 7, 64, 64, 7);
        run(0, 7, 64, 64, 0, 1'b0, 3, 30, -1);
        run(0, 7, 64, 64, 0, 1'b0, 3, -1, -1);

        lane = $urandom_range(0, 5);
        build(1, lane, 7, 64, 64, 10);
        run(1, 7, 64, 64, 0, 1'b1, lane, -1, -1);

        lane = $urandom_range(0, 5);
        build(2, lane, 7, 64, 200, 7);
        run(2, 7, 64, 200, 100, 1'b0, lane, -1, -1);

        build(3, 0, 1, 64, 64, 1);
        run(3, 1, 64, 64, 0, 1'b0, 0, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
